// File: rtl/bit_scan_ctrl_pkg.sv
// Shared types and helpers for the bit_scan_ctrl sequencer.
package bit_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int unsigned clog2_fn(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bit_scan_ctrl_bit_test.sv
// Combinational bit probe: hit = word[ptr].
module bit_scan_ctrl_bit_test
  import bit_scan_ctrl_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    word,
  input  logic [IDXW-1:0] ptr,
  output logic            hit
);

  always_comb begin
    hit = word[ptr];
  end

endmodule

// File: rtl/bit_scan_ctrl.sv
// Walks a captured word LSB->MSB and emits each set-bit position over valid/ready,
// then pulses done with the number of set bits found.
module bit_scan_ctrl
  import bit_scan_ctrl_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    word,
  input  logic            idx_ready,
  output logic            busy,
  output logic            idx_valid,
  output logic [IDXW-1:0] idx,
  output logic            done,
  output logic [IDXW:0]   count
);

  if (IDXW != int'(clog2_fn(N))) begin : g_bad_idxw
    $error("bit_scan_ctrl: IDXW must equal clog2(N)");
  end

  state_t          state, state_d;
  logic [IDXW-1:0] ptr, ptr_d;
  logic [N-1:0]    shadow, shadow_d;
  logic [IDXW:0]   count_d;
  logic [IDXW-1:0] idx_d;
  logic            idx_valid_d, busy_d, done_d;
  logic            hit, ptr_last;

  bit_scan_ctrl_bit_test #(.N(N), .IDXW(IDXW)) u_bit_test (
    .word (shadow),
    .ptr  (ptr),
    .hit  (hit)
  );

  assign ptr_last = (ptr == IDXW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      shadow    <= '0;
      count     <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      shadow    <= shadow_d;
      count     <= count_d;
      idx       <= idx_d;
      idx_valid <= idx_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Outputs are registered copies of next-state decodes so busy/done line up with state.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    shadow_d    = shadow;
    count_d     = count;
    idx_d       = idx;
    idx_valid_d = idx_valid;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          shadow_d = word;
          ptr_d    = '0;
          count_d  = '0;
          state_d  = ST_SCAN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          idx_d       = ptr;
          count_d     = count + (IDXW + 1)'(1);
          idx_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end else if (ptr_last) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr + IDXW'(1);
        end
      end
      ST_EMIT: begin
        if (idx_ready) begin
          idx_valid_d = 1'b0;
          if (ptr_last) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr + IDXW'(1);
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SCAN) || (state_d == ST_EMIT);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_bit_scan_ctrl.sv
// Scoreboard bench for bit_scan_ctrl: stimulus pushes expected idx/done events, a negedge monitor pops them.
module tb_bit_scan_ctrl;

  localparam int N    = 8;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [N-1:0]    word = '0;
  logic            idx_ready;
  logic            busy, idx_valid, done;
  logic [IDXW-1:0] idx;
  logic [IDXW:0]   count;

  bit_scan_ctrl #(.N(N), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .word      (word),
    .idx_ready (idx_ready),
    .busy      (busy),
    .idx_valid (idx_valid),
    .idx       (idx),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int unsigned val;
    int unsigned at_cyc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: either a level, or 3 stalled cycles per emission
  logic        stall_mode = 1'b0;
  logic        ready_level = 1'b0;
  logic        stall_ready = 1'b0;
  int unsigned wait_cnt = 0;
  assign idx_ready = stall_mode ? stall_ready : ready_level;

  always @(posedge clk) begin
    #1;
    if (idx_valid) begin
      if (wait_cnt == 3) begin
        stall_ready = 1'b1;
        wait_cnt = 0;
      end else begin
        stall_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      stall_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic            prev_valid = 1'b0;
  logic            prev_hs = 1'b0;
  logic [IDXW-1:0] prev_idx = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        chk("stall_valid_held", idx_valid, 1);
        chk("stall_idx_held", idx, prev_idx);
      end
      if (idx_valid && idx_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_idx", idx, 999);
        end else begin
          e = q.pop_front();
          chk("idx_order_kind", e.is_done, 0);
          chk("idx", idx, e.val);
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", count, 999);
        end else begin
          e = q.pop_front();
          chk("done_order_kind", e.is_done, 1);
          chk("count", count, e.val);
          chk("done_cycle", cyc, e.at_cyc);
        end
      end
      prev_valid = idx_valid;
      prev_hs    = idx_valid && idx_ready;
      prev_idx   = idx;
    end
  end

  // Called at posedge+1; pushes expectations then pulses start for one cycle.
  task automatic issue(input logic [N-1:0] w, input int unsigned stall_per_bit);
    int unsigned k;
    int unsigned start_edge;
    exp_t e;
    start_edge = cyc + 1;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) begin
        e.is_done = 1'b0; e.val = i; e.at_cyc = 0;
        q.push_back(e);
        k++;
      end
    end
    e.is_done = 1'b1; e.val = k; e.at_cyc = start_edge + N + k + stall_per_bit * k;
    q.push_back(e);
    start = 1'b1;
    word  = w;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned bound, output int unsigned busy_cnt);
    bit found;
    found = 1'b0;
    busy_cnt = 0;
    for (int unsigned i = 0; i < bound; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    if (!found) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int unsigned bc;
    bit seen;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_idx", idx, 0);

    // 1: stall in EMIT at idx 0, then async reset mid-cycle
    ready_level = 1'b0;
    start = 1'b1; word = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (idx_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("stall_reached", seen, 1);
    chk("stall_idx0", idx, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_idx_valid", idx_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_count", count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_valid", idx_valid, 0);

    // 2: mixed pattern, ready high
    ready_level = 1'b1;
    issue(8'b1011_0010, 0);
    wait_done(40, bc);
    repeat (2) @(posedge clk); #1;

    // 3: empty word
    issue(8'h00, 0);
    wait_done(40, bc);
    chk("zero_busy_cycles", bc, 8);
    chk("zero_done_busy", busy, 0);
    repeat (2) @(posedge clk); #1;

    // 4: all ones, 3-cycle stall per emission
    stall_mode = 1'b1;
    issue(8'hFF, 3);
    wait_done(100, bc);
    stall_mode = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 5: start while busy ignored, then back-to-back start in DONE
    issue(8'b1000_0000, 0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; word = 8'h01;
    @(posedge clk); #1;
    start = 1'b0; word = 8'h55;
    wait_done(40, bc);
    issue(8'h03, 0);
    wait_done(40, bc);
    repeat (2) @(posedge clk); #1;

    // 6: MSB only
    issue(8'b1000_0000, 0);
    wait_done(40, bc);
    repeat (3) @(posedge clk); #1;
    chk("final_idle_busy", busy, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
